spi_slave_apb_bridge: RTL and testbench

- SPI slave, mode 0, single lane, MSB first. Terminates the serial link driven by the APB-attached SPI master and turns each framed SPI transaction into one APB master access.
- Provides the responder end of the SPI path, so an external or loopback SPI master can read and write the APB register space.
- SPI inputs are oversampled in the clk_i domain.

---
 rtl/spi_slave_apb_bridge.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_spi_slave_apb_bridge.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_apb_bridge.sv
// SPI mode-0 slave that turns each framed SPI transaction into one APB master access.
// Optional APB watchdog: define SPI_APB_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module spi_slave_apb_bridge #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      spi_sclk_i,
  input  logic                      spi_csn_i,
  input  logic                      spi_sdi_i,
  output logic                      spi_sdo_o,
  output logic                      spi_oe_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [31:0]               pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [31:0]               prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i,
  output logic                      done_o,
  output logic                      err_o
);

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_CMD        = 4'd1;
  localparam logic [3:0] ST_ADDR       = 4'd2;
  localparam logic [3:0] ST_WDATA      = 4'd3;
  localparam logic [3:0] ST_APB_SETUP  = 4'd4;
  localparam logic [3:0] ST_APB_ACCESS = 4'd5;
  localparam logic [3:0] ST_DUMMY      = 4'd6;
  localparam logic [3:0] ST_RDATA      = 4'd7;
  localparam logic [3:0] ST_IGNORE     = 4'd8;

  localparam logic [7:0]  CMD_WRITE   = 8'h02;
  localparam logic [7:0]  CMD_READ    = 8'h03;
  localparam logic [31:0] RD_FALLBACK = 32'hDEADBEEF;

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("spi_slave_apb_bridge: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, sdi_sync_q;
  logic                   sclk_prev_q, csn_prev_q;
  logic                   sclk_s, csn_s, sdi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [3:0]                state_q, state_d;
  logic [3:0]                apb_q, apb_d;
  logic [5:0]                bitcnt_q, bitcnt_d;
  logic                      is_rd_q, is_rd_d;
  logic                      pend_q, pend_d;
  logic                      req_write_q, req_write_d;
  logic                      rd_valid_q, rd_valid_d;
  logic                      err_q, err_d, err_set;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic [31:0]               sr_q, sr_d, sr_shift;
  logic [APB_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [31:0]               req_wdata_q, req_wdata_d;
  logic [31:0]               rdata_q, rdata_d;
  logic [31:0]               tx_q, tx_d;
  logic                      apb_done, tmo_hit, apb_end, rd_now;
  logic [31:0]               rd_word;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = csn_prev_q & ~csn_s;
  assign cs_rise   = ~csn_prev_q & csn_s;
  assign sr_shift  = {sr_q[30:0], sdi_s};

  assign apb_done = (apb_q == ST_APB_ACCESS) && pready_i;

`ifdef SPI_APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts completed ACCESS cycles; the access is abandoned on the TIMEOUT_CYCLES-th one.
  assign tmo_hit = (apb_q == ST_APB_ACCESS) && !pready_i &&
                   (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign tmo_d   = ((apb_q == ST_APB_ACCESS) && !apb_done && !tmo_hit) ? tmo_q + 1'b1 : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign apb_end = apb_done | tmo_hit;
  assign rd_now  = apb_end & ~pwrite_q;
  assign rd_word = apb_done ? prdata_i : RD_FALLBACK;

  always_comb begin
    state_d     = state_q;
    apb_d       = apb_q;
    bitcnt_d    = bitcnt_q;
    is_rd_d     = is_rd_q;
    pend_d      = pend_q;
    req_write_d = req_write_q;
    rd_valid_d  = rd_valid_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    sr_d        = sr_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rdata_d     = rdata_q;
    tx_d        = tx_q;
    err_set     = 1'b0;

    // APB engine runs independently of the serial frame so an access can outlive its CS window.
    case (apb_q)
      ST_IDLE: begin
        if (pend_q) begin
          apb_d      = ST_APB_SETUP;
          paddr_d    = req_addr_q;
          pwdata_d   = req_wdata_q;
          pwrite_d   = req_write_q;
          pend_d     = 1'b0;
          rd_valid_d = 1'b0;
        end
      end
      ST_APB_SETUP: apb_d = ST_APB_ACCESS;
      ST_APB_ACCESS: begin
        if (apb_end) begin
          apb_d   = ST_IDLE;
          err_set = tmo_hit | (apb_done & pslverr_i);
          if (!pwrite_q) begin
            rd_valid_d = 1'b1;
            rdata_d    = rd_word;
          end
        end
      end
      default: apb_d = ST_IDLE;
    endcase

    case (state_q)
      ST_CMD: begin
        if (sclk_rise) begin
          sr_d     = sr_shift;
          bitcnt_d = bitcnt_q + 6'd1;
          if (bitcnt_q == 6'd7) begin
            bitcnt_d = 6'd0;
            if (sr_shift[7:0] == CMD_WRITE) begin
              state_d = ST_ADDR;
              is_rd_d = 1'b0;
            end else if (sr_shift[7:0] == CMD_READ) begin
              state_d = ST_ADDR;
              is_rd_d = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
      end
      ST_ADDR: begin
        if (sclk_rise) begin
          sr_d     = sr_shift;
          bitcnt_d = bitcnt_q + 6'd1;
          if (bitcnt_q == 6'd31) begin
            bitcnt_d   = 6'd0;
            req_addr_d = sr_shift[APB_ADDR_WIDTH-1:0];
            if (is_rd_q) begin
              state_d     = ST_DUMMY;
              req_write_d = 1'b0;
              pend_d      = 1'b1;
            end else begin
              state_d = ST_WDATA;
            end
          end
        end
      end
      ST_WDATA: begin
        if (sclk_rise) begin
          sr_d     = sr_shift;
          bitcnt_d = bitcnt_q + 6'd1;
          if (bitcnt_q == 6'd31) begin
            bitcnt_d    = 6'd0;
            req_wdata_d = sr_shift;
            req_write_d = 1'b1;
            pend_d      = 1'b1;
            // Remaining clocks of a complete write frame carry nothing.
            state_d     = ST_IGNORE;
          end
        end
      end
      ST_DUMMY: begin
        if (sclk_rise && bitcnt_q != 6'd8) begin
          bitcnt_d = bitcnt_q + 6'd1;
        end else if (sclk_fall && bitcnt_q == 6'd8) begin
          state_d  = ST_RDATA;
          bitcnt_d = 6'd0;
          if (!pend_q && rd_valid_q) begin
            tx_d = rdata_q;
          end else if (!pend_q && rd_now) begin
            tx_d = rd_word;
          end else begin
            tx_d    = RD_FALLBACK;
            err_set = 1'b1;
          end
        end
      end
      ST_RDATA: begin
        if (sclk_fall) tx_d = {tx_q[30:0], 1'b0};
      end
      default: ;
    endcase

    if (cs_rise) begin
      state_d  = ST_IDLE;
      bitcnt_d = 6'd0;
    end
    if (cs_fall) begin
      state_d  = ST_CMD;
      bitcnt_d = 6'd0;
    end
  end

  assign err_d = cs_fall ? err_set : (err_q | err_set);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '1;
      sdi_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      apb_q       <= ST_IDLE;
      bitcnt_q    <= 6'd0;
      is_rd_q     <= 1'b0;
      pend_q      <= 1'b0;
      req_write_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn_i};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi_i};
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
      state_q     <= state_d;
      apb_q       <= apb_d;
      bitcnt_q    <= bitcnt_d;
      is_rd_q     <= is_rd_d;
      pend_q      <= pend_d;
      req_write_q <= req_write_d;
      rd_valid_q  <= rd_valid_d;
      err_q       <= err_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
    end
  end

  always_ff @(posedge clk_i) begin
    sr_q        <= sr_d;
    req_addr_q  <= req_addr_d;
    req_wdata_q <= req_wdata_d;
    rdata_q     <= rdata_d;
    tx_q        <= tx_d;
  end

  assign spi_oe_o  = (state_q == ST_DUMMY) || (state_q == ST_RDATA);
  assign spi_sdo_o = (state_q == ST_RDATA) & tx_q[31];
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign pwrite_o  = pwrite_q;
  assign psel_o    = (apb_q == ST_APB_SETUP) || (apb_q == ST_APB_ACCESS);
  assign penable_o = (apb_q == ST_APB_ACCESS);
  assign done_o    = apb_end;
  assign err_o     = err_q;

endmodule

// File: tb/tb_spi_slave_apb_bridge.sv
// Self-checking bench for spi_slave_apb_bridge: SPI master model, APB responder, APB scoreboard.
`timescale 1ns/1ps
module tb_spi_slave_apb_bridge;
  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        rst_i, spi_sclk_i, spi_csn_i, spi_sdi_i;
  logic        spi_sdo_o, spi_oe_o;
  logic [31:0] paddr_o, pwdata_o, prdata_i;
  logic        pwrite_o, psel_o, penable_o, pready_i, pslverr_i, done_o, err_o;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } apb_exp_t;

  apb_exp_t    exp_q[$];
  logic [31:0] rd_exp_q[$];
  int checks = 0, errors = 0;
  int done_cnt = 0, apb_cycles = 0;
  int rsp_wait = 0, rsp_cnt = 0;
  logic rsp_err = 1'b0, rsp_stall = 1'b0, tmo_mode = 1'b0;
  logic [31:0] rsp_rdata = 32'h0;

  spi_slave_apb_bridge #(.APB_ADDR_WIDTH(32), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .spi_sclk_i(spi_sclk_i), .spi_csn_i(spi_csn_i),
    .spi_sdi_i(spi_sdi_i), .spi_sdo_o(spi_sdo_o), .spi_oe_o(spi_oe_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o), .psel_o(psel_o),
    .penable_o(penable_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // APB responder: updates just after each rising edge, ready after rsp_wait wait states.
  initial begin
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (psel_o && penable_o && !rsp_stall) begin
        if (rsp_cnt == rsp_wait) begin
          pready_i = 1'b1; pslverr_i = rsp_err; prdata_i = rsp_rdata;
        end else begin
          pready_i = 1'b0; pslverr_i = 1'b0;
        end
        rsp_cnt++;
      end else begin
        pready_i = 1'b0; pslverr_i = 1'b0; rsp_cnt = 0;
      end
    end
  end

  // APB scoreboard: every bus cycle is checked against the oldest expected access.
  initial begin
    logic prev_psel;
    prev_psel = 1'b0;
    forever begin
      @(negedge clk);
      if (psel_o) begin
        apb_cycles++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL apb_unexpected: addr=%h wr=%b, required no APB access", paddr_o, pwrite_o);
        end else begin
          if (paddr_o !== exp_q[0].addr || pwrite_o !== exp_q[0].wr ||
              (exp_q[0].wr && pwdata_o !== exp_q[0].data)) begin
            errors++;
            $display("FAIL apb_req: addr=%h wr=%b wdata=%h, required addr=%h wr=%b wdata=%h",
                     paddr_o, pwrite_o, pwdata_o, exp_q[0].addr, exp_q[0].wr, exp_q[0].data);
          end
          checks++;
          if ((penable_o && !prev_psel) || (!penable_o && prev_psel)) begin
            errors++;
            $display("FAIL apb_phase: penable=%b prev_psel=%b, required one setup cycle before enable",
                     penable_o, prev_psel);
          end
          if (penable_o && pready_i) void'(exp_q.pop_front());
        end
      end
      if (done_o) done_cnt++;
      if (!tmo_mode && (done_o || (psel_o && penable_o && pready_i))) begin
        checks++;
        if (done_o !== (psel_o & penable_o & pready_i)) begin
          errors++;
          $display("FAIL done_pulse: done=%b, required %b", done_o, psel_o & penable_o & pready_i);
        end
      end
      prev_psel = psel_o;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic spi_bit(input logic mosi, output logic miso);
    spi_sdi_i = mosi;
    #(HALF);
    miso = spi_sdo_o;
    spi_sclk_i = 1'b1;
    #(HALF);
    spi_sclk_i = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_csn_i = 1'b0;
    #(HALF);
  endtask

  task automatic cs_high();
    #(HALF);
    spi_csn_i = 1'b1;
    #(2*HALF);
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    logic m;
    for (int i = n - 1; i >= 0; i--) spi_bit(w[i], m);
  endtask

  task automatic spi_write(input logic [31:0] a, input logic [31:0] d);
    cs_low();
    send_word(32'h02, 8);
    send_word(a, 32);
    send_word(d, 32);
    cs_high();
  endtask

  task automatic spi_read(input logic [31:0] a, output logic [31:0] rd, output int dummy_bad,
                          output logic tail, output logic oe_end);
    logic m;
    dummy_bad = 0;
    cs_low();
    send_word(32'h03, 8);
    send_word(a, 32);
    for (int i = 0; i < 8; i++) begin
      spi_bit(1'b1, m);
      if (m !== 1'b0 || spi_oe_o !== 1'b1) dummy_bad++;
    end
    for (int i = 31; i >= 0; i--) begin
      spi_bit(1'b0, m);
      rd[i] = m;
    end
    spi_bit(1'b0, tail);
    #(HALF);
    oe_end = spi_oe_o;
    spi_csn_i = 1'b1;
    #(2*HALF);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL apb_drain: %0d accesses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; spi_csn_i = 1'b1; spi_sclk_i = 1'b0; spi_sdi_i = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({spi_sdo_o, spi_oe_o, pwrite_o, psel_o, penable_o, done_o, err_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: sdo/oe/pwrite/psel/penable/done/err=%b, required 0000000",
               {spi_sdo_o, spi_oe_o, pwrite_o, psel_o, penable_o, done_o, err_o});
    end
    checks++;
    if (paddr_o !== 32'h0 || pwdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: paddr=%h pwdata=%h, required 0", paddr_o, pwdata_o);
    end
    rst_i = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write(input logic [31:0] a, input logic [31:0] d);
    int d0;
    d0 = done_cnt;
    rsp_wait = 0;
    exp_q.push_back('{wr: 1'b1, addr: a, data: d});
    spi_write(a, d);
    wait_drain(200);
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL write_done: %0d pulses, required 1", done_cnt - d0);
    end
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL write_err: err_o=%b, required 0", err_o);
    end
  endtask

  task automatic test_read();
    logic [31:0] rd, expv;
    int bad;
    logic tail, oe_end;
    rsp_wait = 2; rsp_rdata = 32'hCAFEF00D;
    exp_q.push_back('{wr: 1'b0, addr: 32'h20, data: 32'h0});
    rd_exp_q.push_back(32'hCAFEF00D);
    spi_read(32'h20, rd, bad, tail, oe_end);
    expv = rd_exp_q.pop_front();
    checks++;
    if (rd !== expv) begin
      errors++; $display("FAIL read_data: miso=%h, required %h", rd, expv);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL read_dummy: %0d bad dummy bits, required 0", bad);
    end
    checks++;
    if (tail !== 1'b0 || oe_end !== 1'b1) begin
      errors++; $display("FAIL read_tail: extra bit=%b oe=%b, required 0 and 1", tail, oe_end);
    end
    checks++;
    if (spi_oe_o !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL read_end: oe=%b err=%b, required 0 and 0", spi_oe_o, err_o);
    end
    wait_drain(200);
    rsp_wait = 0;
  endtask

  task automatic test_abort();
    int a0;
    a0 = apb_cycles;
    cs_low();
    send_word(32'h02, 8);
    send_word(32'h00001234, 16);
    cs_high();
    repeat (20) @(negedge clk);
    checks++;
    if (apb_cycles != a0 || spi_oe_o !== 1'b0) begin
      errors++;
      $display("FAIL abort: %0d APB cycles oe=%b, required 0 and 0", apb_cycles - a0, spi_oe_o);
    end
    test_write(32'h44, 32'h0BADF00D);
  endtask

  task automatic test_illegal_cmd();
    int a0, d0, oe_bad;
    logic m;
    a0 = apb_cycles; d0 = done_cnt; oe_bad = 0;
    cs_low();
    send_word(32'h9F, 8);
    for (int i = 0; i < 64; i++) begin
      spi_bit(1'($urandom_range(0, 1)), m);
      if (spi_oe_o !== 1'b0 || m !== 1'b0) oe_bad++;
    end
    cs_high();
    checks++;
    if (oe_bad != 0) begin
      errors++; $display("FAIL illegal_oe: %0d bits with MISO driven, required 0", oe_bad);
    end
    checks++;
    if (apb_cycles != a0 || done_cnt != d0) begin
      errors++;
      $display("FAIL illegal_apb: %0d APB cycles %0d done, required 0 and 0",
               apb_cycles - a0, done_cnt - d0);
    end
  endtask

  task automatic test_slverr();
    rsp_err = 1'b1;
    exp_q.push_back('{wr: 1'b1, addr: 32'h50, data: 32'h11112222});
    spi_write(32'h50, 32'h11112222);
    wait_drain(200);
    rsp_err = 1'b0;
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL slverr_set: err_o=%b, required 1", err_o);
    end
    exp_q.push_back('{wr: 1'b1, addr: 32'h54, data: 32'h33334444});
    cs_low();
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL slverr_clear: err_o=%b after CS fall, required 0", err_o);
    end
    send_word(32'h02, 8);
    send_word(32'h54, 32);
    send_word(32'h33334444, 32);
    cs_high();
    wait_drain(200);
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL slverr_next: err_o=%b, required 0", err_o);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
`ifdef SPI_APB_TIMEOUT_EN
    rsp_wait = 10;
`else
    rsp_wait = 60;
`endif
    exp_q.push_back('{wr: 1'b1, addr: 32'h60, data: 32'hAAAA0001});
    exp_q.push_back('{wr: 1'b1, addr: 32'h64, data: 32'hBBBB0002});
    spi_write(32'h60, 32'hAAAA0001);
    cs_low();
`ifndef SPI_APB_TIMEOUT_EN
    checks++;
    if (psel_o !== 1'b1) begin
      errors++; $display("FAIL b2b_overlap: psel=%b at new CS fall, required 1", psel_o);
    end
`endif
    send_word(32'h02, 8);
    send_word(32'h64, 32);
    send_word(32'hBBBB0002, 32);
    cs_high();
    wait_drain(400);
    checks++;
    if (done_cnt - d0 != 2 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: %0d pulses err=%b, required 2 and 0", done_cnt - d0, err_o);
    end
    rsp_wait = 0;
  endtask

  task automatic test_late_read();
    logic [31:0] rd, expv;
    int bad, d0;
    logic tail, oe_end;
    d0 = done_cnt;
    rsp_wait = 200; rsp_rdata = 32'h12345678;
    exp_q.push_back('{wr: 1'b0, addr: 32'h40, data: 32'h0});
    rd_exp_q.push_back(32'hDEADBEEF);
    spi_read(32'h40, rd, bad, tail, oe_end);
    expv = rd_exp_q.pop_front();
    checks++;
    if (rd !== expv || err_o !== 1'b1) begin
      errors++; $display("FAIL late_read: miso=%h err=%b, required %h and 1", rd, err_o, expv);
    end
    wait_drain(400);
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++; $display("FAIL late_done: %0d pulses, required 1", done_cnt - d0);
    end
    rsp_wait = 0;
  endtask

  task automatic test_timeout();
    logic [31:0] rd, expv;
    int bad, d0;
    logic tail, oe_end;
    d0 = done_cnt;
    tmo_mode = 1'b1; rsp_stall = 1'b1;
    exp_q.push_back('{wr: 1'b0, addr: 32'h30, data: 32'h0});
    rd_exp_q.push_back(32'hDEADBEEF);
    spi_read(32'h30, rd, bad, tail, oe_end);
    expv = rd_exp_q.pop_front();
    checks++;
    if (rd !== expv || err_o !== 1'b1) begin
      errors++; $display("FAIL timeout_read: miso=%h err=%b, required %h and 1", rd, err_o, expv);
    end
    checks++;
    if (done_cnt - d0 != 1 || psel_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_done: %0d pulses psel=%b, required 1 and 0", done_cnt - d0, psel_o);
    end
    exp_q.delete();
    tmo_mode = 1'b0; rsp_stall = 1'b0;
  endtask

  task automatic test_reset_mid_apb();
    int i;
    rsp_stall = 1'b1;
    exp_q.push_back('{wr: 1'b1, addr: 32'h70, data: 32'h77778888});
    cs_low();
    send_word(32'h02, 8);
    send_word(32'h70, 32);
    send_word(32'h77778888, 32);
    for (i = 0; i < 200 && !(psel_o && penable_o); i++) @(negedge clk);
    checks++;
    if (!(psel_o && penable_o)) begin
      errors++; $display("FAIL rst_apb_start: psel=%b penable=%b, required 1 1", psel_o, penable_o);
    end
    rst_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (psel_o !== 1'b0 || penable_o !== 1'b0) begin
      errors++; $display("FAIL rst_apb_drop: psel=%b penable=%b, required 0 0", psel_o, penable_o);
    end
    @(negedge clk);
    checks++;
    if ({spi_sdo_o, spi_oe_o, pwrite_o, psel_o, penable_o, done_o, err_o} !== 7'b0 ||
        paddr_o !== 32'h0 || pwdata_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_apb_outs: ctrl=%b paddr=%h pwdata=%h, required all 0",
               {spi_sdo_o, spi_oe_o, pwrite_o, psel_o, penable_o, done_o, err_o}, paddr_o, pwdata_o);
    end
    spi_csn_i = 1'b1;
    repeat (5) @(negedge clk);
    exp_q.delete();
    rsp_stall = 1'b0;
    rst_i = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write(32'h00000010, 32'hA5A51234);
    test_read();
    test_abort();
    test_illegal_cmd();
    test_slverr();
    test_back_to_back();
`ifdef SPI_APB_TIMEOUT_EN
    test_timeout();
`else
    test_late_read();
`endif
    test_reset_mid_apb();
    test_write(32'h00000080, 32'h5A5AC3C3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
